// File: rtl/fir_mac_engine.sv
// FIR sequencer: streams samples into a circular data BRAM, 11-tap MAC, streams results.
// Define FIR_SAT_EN for a wide accumulator with saturated 32-bit results.
module fir_mac_engine #(
  parameter int NUM_TAP    = 11,
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [BIT_WIDTH-1:0]  ss_tdata,
  input  logic                  ss_tvalid,
  output logic                  ss_tready,
  output logic [BIT_WIDTH-1:0]  sm_tdata,
  output logic                  sm_tvalid,
  input  logic                  sm_tready,
  output logic                  sm_tlast,
  output logic [ADDR_WIDTH-1:0] tap_A,
  output logic                  tap_WE,
  input  logic [BIT_WIDTH-1:0]  tap_Do,
  output logic [ADDR_WIDTH-1:0] data_A,
  output logic                  data_WE,
  output logic [BIT_WIDTH-1:0]  data_Di,
  input  logic [BIT_WIDTH-1:0]  data_Do
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    WRITE,
    MAC,
    OUT,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] NT =
    ADDR_WIDTH'(NUM_TAP);
  localparam logic [ADDR_WIDTH-1:0] NT_M1 =
    ADDR_WIDTH'(NUM_TAP - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);

  state_t                state;
  state_t                nxt;
  logic [31:0]           len_reg;
  logic [31:0]           cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] tcnt;
  logic [ADDR_WIDTH-1:0] rd_a;
  logic [BIT_WIDTH-1:0]  smp;
  logic [BIT_WIDTH-1:0]  res;
  logic                  out_vld;
  logic [BIT_WIDTH-1:0]  out_dat;
  logic                  out_last;
  logic                  done_reg;
  logic                  sm_hs;

`ifdef FIR_SAT_EN
  localparam int AW = 2 * BIT_WIDTH + 4;

  logic signed [2*BIT_WIDTH-1:0] tap_x;
  logic signed [2*BIT_WIDTH-1:0] dat_x;
  logic signed [2*BIT_WIDTH-1:0] prod;
  logic signed [AW-1:0]          acc;
  logic signed [AW-1:0]          prod_x;
  logic [AW-BIT_WIDTH:0]         hi;

  assign tap_x  = {{BIT_WIDTH{tap_Do[BIT_WIDTH-1]}},
                   tap_Do};
  assign dat_x  = {{BIT_WIDTH{data_Do[BIT_WIDTH-1]}},
                   data_Do};
  assign prod   = tap_x * dat_x;
  assign prod_x = {{4{prod[2*BIT_WIDTH-1]}}, prod};
  assign hi     = acc[AW-1:BIT_WIDTH-1];

  // In range only when all bits above the result sign agree
  always_comb begin
    res = acc[BIT_WIDTH-1:0];
    unique case (1'b1)
      (!acc[AW-1] && (|hi)):
        res = {1'b0, {(BIT_WIDTH-1){1'b1}}};
      (acc[AW-1] && !(&hi)):
        res = {1'b1, {(BIT_WIDTH-1){1'b0}}};
      default: ;
    endcase
  end
`else
  logic [BIT_WIDTH-1:0] prod;
  logic [BIT_WIDTH-1:0] acc;
  logic [BIT_WIDTH-1:0] prod_x;

  assign prod   = BIT_WIDTH'($signed(tap_Do) *
                             $signed(data_Do));
  assign prod_x = prod;
  assign res    = acc;
`endif

  assign sm_hs     = out_vld & sm_tready;
  assign ap_idle   = (state == IDLE);
  assign ap_done   = done_reg;
  assign tap_WE    = 1'b0;
  assign sm_tvalid = out_vld;
  assign sm_tdata  = out_dat;
  assign sm_tlast  = out_last;

  // Newest sample sits at wr_ptr; tap k pairs with k samples back
  assign rd_a = (wr_ptr >= tcnt) ?
                (wr_ptr - tcnt) :
                (wr_ptr + NT - tcnt);

  always_comb begin
    nxt       = state;
    ss_tready = 1'b0;
    tap_A     = '0;
    data_A    = '0;
    data_WE   = 1'b0;
    data_Di   = '0;
    unique case (state)
      IDLE: begin
        if (ap_start)
          nxt = (data_length == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        data_WE = 1'b1;
        data_A  = tcnt;
        if (tcnt == NT_M1)
          nxt = WAIT_IN;
      end
      WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid)
          nxt = WRITE;
      end
      WRITE: begin
        data_WE = 1'b1;
        data_A  = wr_ptr;
        data_Di = smp;
        nxt     = MAC;
      end
      MAC: begin
        if (tcnt < NT) begin
          tap_A  = tcnt;
          data_A = rd_a;
        end
        if (tcnt == NT)
          nxt = OUT;
      end
      OUT: begin
        if (sm_hs)
          nxt = out_last ? DONE : WAIT_IN;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      len_reg  <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      tcnt     <= '0;
      acc      <= '0;
      smp      <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            len_reg  <= data_length;
            cnt      <= '0;
            tcnt     <= '0;
            done_reg <= (data_length == '0);
          end
        end
        CLEAR: begin
          if (tcnt == NT_M1) begin
            tcnt   <= '0;
            wr_ptr <= '0;
          end else begin
            tcnt <= tcnt + ONE;
          end
        end
        WAIT_IN: begin
          if (ss_tvalid)
            smp <= ss_tdata;
        end
        WRITE: begin
          acc  <= '0;
          tcnt <= '0;
        end
        MAC: begin
          // BRAM data lags the address by one cycle
          if (tcnt != '0)
            acc <= acc + prod_x;
          tcnt <= (tcnt == NT) ? '0 : tcnt + ONE;
        end
        OUT: begin
          if (!out_vld) begin
            out_vld  <= 1'b1;
            out_dat  <= res;
            out_last <= (cnt + 32'd1 == len_reg);
          end else if (sm_tready) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_dat  <= '0;
            cnt      <= cnt + 32'd1;
            wr_ptr   <= (wr_ptr == NT_M1) ?
                        '0 : wr_ptr + ONE;
            if (out_last)
              done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Randomized bench for fir_mac_engine with BRAM models and a direct-form FIR reference.
// Honours FIR_SAT_EN in the reference model.
module tb_fir_mac_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_done;
  logic        ap_idle;
  logic [31:0] ss_tdata;
  logic        ss_tvalid;
  logic        ss_tready;
  logic [31:0] sm_tdata;
  logic        sm_tvalid;
  logic        sm_tready;
  logic        sm_tlast;
  logic [11:0] tap_A;
  logic        tap_WE;
  logic [31:0] tap_Do;
  logic [11:0] data_A;
  logic        data_WE;
  logic [31:0] data_Di;
  logic [31:0] data_Do;

  fir_mac_engine dut (
    .CLK(CLK), .RST(RST),
    .ap_start(ap_start), .data_length(data_length),
    .ap_done(ap_done), .ap_idle(ap_idle),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid),
    .ss_tready(ss_tready),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid),
    .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_A(tap_A), .tap_WE(tap_WE), .tap_Do(tap_Do),
    .data_A(data_A), .data_WE(data_WE),
    .data_Di(data_Di), .data_Do(data_Do)
  );

  always #5 CLK = ~CLK;

  logic [31:0] tap_mem [0:4095];
  logic [31:0] dmem    [0:4095];

  always @(posedge CLK) begin
    tap_Do <= tap_mem[tap_A];
    if (data_WE) dmem[data_A] <= data_Di;
    else         data_Do <= dmem[data_A];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int taps [11];
  int xs [$];
  logic [31:0] got [$];
  int hs_cyc [0:63];

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_y(input int n);
    logic signed [67:0] s;
    longint p;
    s = '0;
    for (int k = 0; k < 11; k++) begin
      if (n - k >= 0) begin
        p = longint'(taps[k]) * longint'(xs[n-k]);
        s = s + 68'(p);
      end
    end
`ifdef FIR_SAT_EN
    if (s > 68'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -68'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic load_taps();
    for (int k = 0; k < 11; k++) tap_mem[k] = taps[k];
  endtask

  task automatic produce(input int len, input bit poke);
    for (int i = 0; i < len; i++) begin
      int b;
      b = 0;
      ss_tdata  = xs[i];
      ss_tvalid = 1'b1;
      while (!ss_tready && b < 2000) begin
        @(negedge CLK);
        b++;
      end
      if (!ss_tready) begin
        chk("ss_timeout", 64'(i), 64'(len));
        ss_tvalid = 1'b0;
        return;
      end
      @(posedge CLK);
      @(negedge CLK);
      hs_cyc[i] = cyc;
      ss_tvalid = 1'b0;
      if (poke && i == 1) begin
        ap_start = 1'b1;
        @(negedge CLK);
        ap_start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  task automatic consume(input int len, input int mode);
    int j, budget, stall;
    bit seen;
    logic [31:0] held;
    j = 0; budget = 0; stall = 0; seen = 0; held = '0;
    while (j < len && budget < len * 100 + 200) begin
      @(negedge CLK);
      budget++;
      if (sm_tvalid) begin
        if (!seen) begin
          seen = 1;
          held = sm_tdata;
          chk("latency", 64'(cyc - hs_cyc[j]), 64'd14);
          if (mode == 1 && j == 1) stall = 20;
        end else begin
          chk("hold", sm_tdata, held);
        end
        if (stall > 0) begin
          sm_tready = 1'b0;
          stall--;
          chk("bp_ss_tready", ss_tready, 1'b0);
        end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
          sm_tready = 1'b0;
        end else begin
          sm_tready = 1'b1;
          chk("y", sm_tdata, ref_y(j));
          chk("tlast", sm_tlast, j == len - 1);
          got.push_back(sm_tdata);
          j++;
          seen = 0;
        end
      end else begin
        sm_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (j < len) chk("sm_timeout", 64'(j), 64'(len));
  endtask

  task automatic run(input int len, input int mode, input bit poke);
    int b;
    got.delete();
    @(negedge CLK);
    data_length = len;
    ap_start = 1'b1;
    @(negedge CLK);
    ap_start = 1'b0;
    chk("start_done", ap_done, len == 0);
    fork
      produce(len, poke);
      consume(len, mode);
    join
    b = 0;
    while (!ap_done && b < 100) begin
      @(negedge CLK);
      b++;
    end
    chk("done", ap_done, 1'b1);
    @(negedge CLK);
    chk("idle_after", ap_idle, 1'b1);
    chk("done_hold", ap_done, 1'b1);
  endtask

  task automatic rand_data(input int n);
    for (int k = 0; k < 11; k++) taps[k] = $urandom;
    load_taps();
    xs.delete();
    for (int i = 0; i < n; i++) xs.push_back($urandom);
  endtask

  initial begin
    RST = 1'b1; ap_start = 1'b0; data_length = '0;
    ss_tdata = '0; ss_tvalid = 1'b0; sm_tready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_idle", ap_idle, 1'b1);
    chk("rst_done", ap_done, 1'b0);
    chk("rst_sm_tvalid", sm_tvalid, 1'b0);
    chk("rst_sm_tdata", sm_tdata, 32'h0);
    chk("rst_sm_tlast", sm_tlast, 1'b0);
    chk("rst_ss_tready", ss_tready, 1'b0);
    chk("rst_addr", {tap_A, data_A}, 24'h0);
    chk("rst_we", {tap_WE, data_WE}, 2'b00);
    RST = 1'b0;

    for (int k = 0; k < 11; k++) taps[k] = k;
    load_taps();
    xs.delete();
    xs.push_back(1);
    for (int i = 1; i < 12; i++) xs.push_back(0);
    run(12, 0, 0);
    chk("imp_y5", got[5], 32'd5);
    chk("imp_y10", got[10], 32'd10);
    chk("imp_y11", got[11], 32'd0);

    for (int k = 0; k < 11; k++) taps[k] = 1;
    load_taps();
    xs.delete();
    for (int i = 1; i <= 15; i++) xs.push_back(i);
    run(15, 0, 0);
    chk("wrap_y10", got[10], 32'd66);
    chk("wrap_y14", got[14], 32'd110);

    for (int k = 0; k < 11; k++) taps[k] = 32'h7FFFFFFF;
    load_taps();
    xs.delete();
    xs.push_back(2);
    run(1, 0, 0);
`ifdef FIR_SAT_EN
    chk("ovf", got[0], 32'h7FFFFFFF);
`else
    chk("ovf", got[0], 32'hFFFFFFFE);
`endif

    rand_data(6);
    run(6, 1, 0);
    chk("bp_count", 64'(got.size()), 64'd6);

    rand_data(20);
    run(20, 2, 1);

    run(0, 0, 0);

    rand_data(5);
    @(negedge CLK);
    data_length = 5;
    ap_start = 1'b1;
    @(negedge CLK);
    ap_start = 1'b0;
    produce(1, 0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_tvalid", sm_tvalid, 1'b0);
    chk("rst_mid_idle", ap_idle, 1'b1);
    chk("rst_mid_done", ap_done, 1'b0);

    rand_data(8);
    run(8, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
